// File: rtl/hex_scan_pkg.sv
// Shared types and register map for the multiplexed 4-digit hex display scanner.
package hex_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GHOST
  } scan_state_e;

  localparam logic [1:0] ADDR_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned STAT_IDX_LSB   = 0;
  localparam int unsigned STAT_DRIVE_BIT = 2;

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low 7-segment glyph (bit6..0 = g..a).
module hex_seg_decode (
  input  logic [3:0] value,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = '1;
    case (value)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = '1;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Avalon-MM controlled scanner for a 4-digit common-anode hex display with
// inter-digit ghost blanking.
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GHOST_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  seg_n,
  output logic [3:0]  dig_n
);

  scan_state_e state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;

  logic [15:0] digits, digits_q;
  logic [3:0]  dp_on, dp_on_q;
  logic [3:0]  blank, blank_q;
  logic        enable;

  logic        wr;
  logic [6:0]  glyph;
  logic [7:0]  seg_d;
  logic [3:0]  dig_d;
  logic        unused_wd;

  assign wr        = chipselect && !write_n;
  assign unused_wd = ^writedata[31:16];

  // Display shadows add one stage so register writes reach seg_n two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits   <= '0;
      dp_on    <= '0;
      blank    <= '0;
      enable   <= 1'b0;
      digits_q <= '0;
      dp_on_q  <= '0;
      blank_q  <= '0;
    end else begin
      digits_q <= digits;
      dp_on_q  <= dp_on;
      blank_q  <= blank;
      if (wr) begin
        case (address)
          ADDR_DIGITS: digits <= writedata[15:0];
          ADDR_MASK: begin
            dp_on <= writedata[3:0];
            blank <= writedata[7:4];
          end
          ADDR_CTRL:   enable <= writedata[CTRL_EN_BIT];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DRIVE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        DRIVE: begin
          if (cnt == 16'(SCAN_DIV - 1)) begin
            state_nxt = GHOST;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        GHOST: begin
          if (cnt == 16'(GHOST_CYC - 1)) begin
            state_nxt = DRIVE;
            idx_nxt   = idx + 2'd1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  hex_seg_decode u_decode (
    .value (digits_q[{idx, 2'b00} +: 4]),
    .glyph (glyph)
  );

  always_comb begin
    dig_d = '1;
    seg_d = '1;
    if (state == DRIVE) begin
      dig_d[idx] = 1'b0;
      if (!blank_q[idx]) seg_d = {~dp_on_q[idx], glyph};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n <= '1;
      dig_n <= '1;
    end else begin
      seg_n <= seg_d;
      dig_n <= dig_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DIGITS: readdata[15:0] = digits;
      ADDR_MASK:   readdata[7:0]  = {blank, dp_on};
      ADDR_CTRL:   readdata[CTRL_EN_BIT] = enable;
      ADDR_STATUS: begin
        readdata[STAT_IDX_LSB +: 2] = idx;
        readdata[STAT_DRIVE_BIT]    = (state == DRIVE);
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomized bench for hex_scan_ctrl against a scan-position reference model.
module tb_hex_scan_ctrl;

  localparam int SD  = 4;
  localparam int GC  = 2;
  localparam int PER = SD + GC;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [15:0] m_digits, m_digits_d;
  logic [7:0]  m_mask, m_mask_d;
  bit          m_en, m_run;
  int          m_t;
  logic [3:0]  exp_dig;
  logic [7:0]  exp_seg;

  hex_scan_ctrl #(.SCAN_DIV(SD), .GHOST_CYC(GC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Scan position t counts cycles since scanning began; digit and phase follow by arithmetic.
  function automatic logic [11:0] model_out(input bit run, input int t,
                                            input logic [15:0] dg, input logic [7:0] mk);
    int p, d;
    logic [3:0] dg_v;
    logic [7:0] sg;
    if (!run) return {4'hF, 8'hFF};
    p = t % (4 * PER);
    d = p / PER;
    if ((p % PER) >= SD) return {4'hF, 8'hFF};
    dg_v = 4'hF;
    dg_v[d] = 1'b0;
    sg = GLYPH[dg[4*d +: 4]];
    sg[7] = ~mk[d];
    if (mk[4+d]) sg = 8'hFF;
    return {dg_v, sg};
  endfunction

  function automatic bit model_driving();
    return m_run && ((m_t % PER) < SD);
  endfunction

  function automatic bit model_ghost();
    return m_run && ((m_t % PER) >= SD);
  endfunction

  function automatic int model_digit();
    return m_run ? (m_t % (4 * PER)) / PER : 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return {16'h0, m_digits};
      2'd1: return {24'h0, m_mask};
      2'd2: return {31'h0, m_en};
      default: return {29'h0, model_driving(), 2'(model_digit())};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_digits = '0; m_digits_d = '0; m_mask = '0; m_mask_d = '0;
      m_en = 1'b0; m_run = 1'b0; m_t = 0;
      exp_dig = 4'hF; exp_seg = 8'hFF;
    end else begin
      {exp_dig, exp_seg} = model_out(m_run, m_t, m_digits_d, m_mask_d);
      m_digits_d = m_digits;
      m_mask_d   = m_mask;
      if (!m_en) begin
        m_run = 1'b0;
        m_t   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t++;
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_digits = writedata[15:0];
          2'd1: m_mask   = writedata[7:0];
          2'd2: m_en     = writedata[0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("dig_n", {28'h0, dig_n}, {28'h0, exp_dig});
      check("seg_n", {24'h0, seg_n}, {24'h0, exp_seg});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    check($sformatf("read%0d", a), readdata, model_read(a));
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input bit ghost, input int dig);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((ghost ? model_ghost() : model_driving()) && model_digit() == dig) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, {31'h0, found}, 32'h1);
  endtask

  initial begin
    // reset values and register readback
    idle(3);
    check("rst_seg", {24'h0, seg_n}, 32'hFF);
    check("rst_dig", {28'h0, dig_n}, 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    for (int a = 0; a < 4; a++) bus_read(2'(a));

    // basic scan of 0x1234 over two full periods
    bus_write(2'd0, 32'h0000_1234);
    bus_write(2'd2, 32'h1);
    idle(50);
    bus_write(2'd2, 32'h1);
    idle(10);

    // dp and blank masks
    bus_write(2'd0, 32'h0000_0008);
    bus_write(2'd1, 32'h0000_0021);
    idle(30);
    bus_read(2'd1);

    // disable during digit 2, then restart
    wait_state("wait_d2", 1'b0, 2);
    bus_write(2'd2, 32'h0);
    bus_read(2'd3);
    idle(4);
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h1);
    idle(8);

    // live digit update mid-drive of digit 0
    wait_state("wait_d0", 1'b0, 0);
    bus_write(2'd0, 32'h0000_FFFF);
    idle(30);

    // writes to STATUS are ignored
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3);

    // asynchronous reset mid-ghost
    wait_state("wait_gh", 1'b1, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_seg", {24'h0, seg_n}, 32'hFF);
    check("arst_dig", {28'h0, dig_n}, 32'hF);
    check("arst_rd", readdata, 32'h0);
    idle(2);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) bus_read(2'(a));
    idle(10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: bus_write(2'd0, $urandom);
        3:       bus_write(2'd1, $urandom);
        4:       bus_write(2'd2, {$urandom_range(0, 0) != 0 ? 31'h0 : $urandom, $urandom_range(0, 3) != 0});
        5:       bus_write(2'd3, $urandom);
        6, 7, 8: bus_read(2'($urandom_range(0, 3)));
        default: idle($urandom_range(1, 6));
      endcase
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit is driven (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter GHOST_CYC, default 16: all-digits-off cycles between digits; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 address  in  2  Avalon-MM slave word address.
REQ-006 chipselect  in  1  slave select.
REQ-007 write_n  in  1  active-low write strobe; write when chipselect && !write_n.
REQ-008 writedata  in  32  write data.
REQ-009 readdata  out  32  combinational read data, zero-wait.
REQ-010 seg_n  out  8  active-low segments: bit7 dp, bits6:0 g..a; registered.
REQ-011 dig_n  out  4  active-low digit enables, at most one low; registered.

Function
REQ-012 Register map, unused bits read 0 and ignore writes:
- 0 DIGITS [15:0]: nibble k = hex value of digit k.
- 1 MASK [3:0] dp_on, [7:4] blank.
- 2 CTRL [0] enable.
- 3 STATUS, read-only: [1:0] idx, [2] driving.
REQ-013 FSM states IDLE, DRIVE, GHOST; encoding is free.
REQ-014 IDLE: dig_n=4'hF, seg_n=8'hFF, idx=0, counters cleared; exit to DRIVE when enable=1.
REQ-015 DRIVE: dig_n low on bit idx only; seg_n = decode(DIGITS[idx]) with dp from dp_on[idx].
- blank[idx]=1 forces seg_n=8'hFF; the digit stays enabled.
- Exactly SCAN_DIV cycles in DRIVE, then GHOST.
REQ-016 GHOST: dig_n=4'hF, seg_n=8'hFF for exactly GHOST_CYC cycles, then DRIVE with idx+1 mod 4 (3 wraps to 0).
REQ-017 Full scan period = 4*(SCAN_DIV+GHOST_CYC) cycles; outputs lag the FSM state by 1 register stage.
REQ-018 A write to DIGITS or MASK during DRIVE changes seg_n on the 2nd clk edge after the write edge; the scan timing does not change.
REQ-019 Writing enable=0 in any state moves the FSM to IDLE on the next edge; outputs are off one cycle later.
REQ-020 Writing enable=1 while already enabled has no effect on idx or counters.
REQ-021 Decode uses the standard 0-F glyphs: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (seg_n with dp off).
REQ-022 Writes to address 3 are ignored.
REQ-023 Reads have no side effects.

Reset
REQ-024 While reset_n=0: state=IDLE, idx=0, counters=0, DIGITS=0, MASK=0, enable=0, seg_n=8'hFF, dig_n=4'hF.
REQ-025 Reset asserted mid-scan forces the REQ-024 values asynchronously, without waiting for a clock edge.
REQ-026 Scanning resumes only after software sets enable again.

Structure
REQ-027 Package hex_scan_pkg holds the FSM state typedef, the register address constants and the CTRL/STATUS bit positions.
REQ-028 The nibble-to-segment table is a combinational sub-module hex_seg_decode: 4-bit in, 7-bit active-low out.

Verification (SCAN_DIV=4, GHOST_CYC=2)
REQ-029 Reset, then read addresses 0-3 -> all read 0; seg_n=FF, dig_n=F.
REQ-030 Write DIGITS=0x1234, CTRL=1 -> dig_n sequence E,F,D,F,B,F,7,F.
- Each low phase lasts 4 cycles; each F gap lasts 2 cycles.
- seg_n per digit: 99, B0, A4, F9.
- Pattern repeats every 24 cycles.
REQ-031 MASK=0x21 with DIGITS=0x0008 -> digit0 seg_n=0x00 (8 with dp), digit1 seg_n=FF while dig_n=D.
REQ-032 Write CTRL=0 during digit 2 DRIVE -> FSM in IDLE next edge, dig_n=F one cycle later.
- Re-enable -> scanning restarts at digit 0.
REQ-033 Write DIGITS=0xFFFF mid-DRIVE of digit 0 -> seg_n becomes 8E two edges after the write; DRIVE length stays 4 cycles.
REQ-034 Assert reset_n low mid-GHOST -> all outputs and registers at reset values immediately; STATUS reads 0 after release.
